// File: rtl/fma16_seq_pkg.sv
// Shared types and constants for the half-precision dot-product sequencer.
package fma16_seq_pkg;

  localparam int FLEN  = 16;
  localparam int FLAGW = 4;

  // Bit positions inside the {invalid,overflow,underflow,inexact} flag vector
  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    EXEC   = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/fma16_dot_seq.sv
// Dot-product sequencer: streams (x,y) pairs into an external fp16 FMA,
// folds every result back into the accumulator and reports one result,
// sticky flags and element count per vector.
module fma16_dot_seq
  import fma16_seq_pkg::*;
#(
  parameter int FMA_LAT = 1,
  parameter int CNTW    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FLEN-1:0]  in_x,
  input  logic [FLEN-1:0]  in_y,
  input  logic             in_last,
  input  logic [FLEN-1:0]  cfg_acc_init,
  input  logic             cfg_negp,
  input  logic [1:0]       cfg_roundmode,
  output logic [FLEN-1:0]  fma_x,
  output logic [FLEN-1:0]  fma_y,
  output logic [FLEN-1:0]  fma_z,
  output logic             fma_mul,
  output logic             fma_add,
  output logic             fma_negp,
  output logic             fma_negz,
  output logic [1:0]       fma_roundmode,
  input  logic [FLEN-1:0]  fma_result,
  input  logic [FLAGW-1:0] fma_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLEN-1:0]  out_result,
  output logic [FLAGW-1:0] out_flags,
  output logic [CNTW-1:0]  out_count
);

  localparam int LATW = (FMA_LAT > 1) ? $clog2(FMA_LAT) : 1;

  // Element count stops at all-ones instead of wrapping
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_capture;

  logic              r_in_ready;
  logic              r_exec;
  logic              r_out_valid;
  logic              r_first;
  logic              r_last;
  logic [LATW-1:0]   r_lat_cnt;
  logic [FLEN-1:0]   r_acc;
  logic [FLEN-1:0]   r_fma_x;
  logic [FLEN-1:0]   r_fma_y;
  logic [FLEN-1:0]   r_fma_z;
  logic              r_negp;
  logic [1:0]        r_rm;
  logic [FLAGW-1:0]  r_flags;
  logic [CNTW-1:0]   r_count;

  // Next-state decode plus the accept/capture strobes used by the datapath
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      ACCEPT: begin
        if (in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (r_lat_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = r_last ? DONE : ACCEPT;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = ACCEPT;
        end
      end
      default: w_state_nxt = ACCEPT;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ACCEPT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake/strobe outputs registered from the next state so they are
  // glitch-free and all read 0 while reset is held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_ready  <= 1'b0;
      r_exec      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == ACCEPT);
      r_exec      <= (w_state_nxt == EXEC);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Operand capture, latency countdown and result fold-back
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_first   <= 1'b1;
      r_last    <= 1'b0;
      r_lat_cnt <= '0;
      r_acc     <= '0;
      r_fma_x   <= '0;
      r_fma_y   <= '0;
      r_fma_z   <= '0;
      r_negp    <= 1'b0;
      r_rm      <= 2'b00;
      r_flags   <= '0;
      r_count   <= '0;
    end else if (w_accept) begin
      r_fma_x   <= in_x;
      r_fma_y   <= in_y;
      r_last    <= in_last;
      r_fma_z   <= r_first ? cfg_acc_init : r_acc;
      r_lat_cnt <= LATW'(FMA_LAT - 1);
      // Vector-wide configuration is frozen at the first pair only
      if (r_first) begin
        r_negp  <= cfg_negp;
        r_rm    <= cfg_roundmode;
        r_flags <= '0;
        r_count <= '0;
      end
    end else if (r_state == EXEC) begin
      if (w_capture) begin
        r_acc           <= fma_result;
        r_flags[FLG_NV] <= r_flags[FLG_NV] | fma_flags[FLG_NV];
        r_flags[FLG_OF] <= r_flags[FLG_OF] | fma_flags[FLG_OF];
        r_flags[FLG_UF] <= r_flags[FLG_UF] | fma_flags[FLG_UF];
        r_flags[FLG_NX] <= r_flags[FLG_NX] | fma_flags[FLG_NX];
        r_count         <= sat_inc(r_count);
        // The next accepted pair starts a new vector only after the last one
        r_first         <= r_last;
      end else begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end
    end
  end

  assign in_ready      = r_in_ready;
  assign fma_x         = r_fma_x;
  assign fma_y         = r_fma_y;
  assign fma_z         = r_fma_z;
  assign fma_mul       = r_exec;
  assign fma_add       = r_exec;
  assign fma_negp      = r_negp;
  assign fma_negz      = 1'b0;
  assign fma_roundmode = r_rm;
  assign out_valid     = r_out_valid;
  assign out_result    = r_acc;
  assign out_flags     = r_flags;
  assign out_count     = r_count;

endmodule
